// File: rtl/serial_add_sched_if.sv
// Request/grant/result bundle for serial_add_sched: two requesters share one bit-serial adder.
// Handshake: reqX is held with stable aX/bX until a one-cycle grantX; done pulses once with sum/done_id.
interface serial_add_sched_if #(
    parameter int N = 8
);
    logic         req0;
    logic [N-1:0] a0;
    logic [N-1:0] b0;
    logic         req1;
    logic [N-1:0] a1;
    logic [N-1:0] b1;
    logic         grant0;
    logic         grant1;
    logic         busy;
    logic         done;
    logic         done_id;
    logic [N:0]   sum;

    modport master (
        output req0, a0, b0, req1, a1, b1,
        input  grant0, grant1, busy, done, done_id, sum
    );

    modport slave (
        input  req0, a0, b0, req1, a1, b1,
        output grant0, grant1, busy, done, done_id, sum
    );
endinterface

// File: rtl/serial_add_sched.sv
// Two-requester scheduler in front of a bit-serial N-bit adder (IDLE -> SHIFT -> DONE).
// Define SERIAL_ADD_SCHED_RR_EN for round-robin tie breaking; default is fixed priority to requester 0.
module serial_add_sched #(
    parameter int N = 8
) (
    input  logic                clock,
    input  logic                reset,
    serial_add_sched_if.slave   bus,
    output logic [1:0]          fsm_state
);
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
    localparam int CW = $clog2(N + 1);

    state_t        state, state_next;
    logic [N-1:0]  sh_a, sh_b, res;
    logic          carry;
    logic [CW-1:0] cnt;
    logic          served;
    logic          any_req, winner, start, last;
    logic          fa_sum, fa_carry;
    logic          grant0_d, grant1_d, done_d, busy_d;

    assign any_req  = bus.req0 | bus.req1;
    assign last     = (cnt == CW'(N));
    assign fa_sum   = sh_a[0] ^ sh_b[0] ^ carry;
    assign fa_carry = (sh_a[0] & sh_b[0]) | (carry & (sh_a[0] ^ sh_b[0]));
    assign fsm_state = state;

`ifdef SERIAL_ADD_SCHED_RR_EN
    logic ptr;

    // On a tie the pointer picks; a lone requester always wins.
    assign winner = (bus.req0 && bus.req1) ? ptr : bus.req1;

    always_ff @(posedge clock) begin
        if (reset)      ptr <= 1'b0;
        else if (start) ptr <= ~winner;
    end
`else
    assign winner = ~bus.req0;
`endif

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_req) state_next = SHIFT;
            SHIFT:   if (last)    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        start    = (state == IDLE) && any_req;
        grant0_d = start && !winner;
        grant1_d = start && winner;
        done_d   = (state == SHIFT) && last;
        busy_d   = (state_next != IDLE);
    end

    // SHIFT spends N edges adding, then one more edge moves the carry into sum[N].
    always_ff @(posedge clock) begin
        if (reset) begin
            bus.grant0  <= 1'b0;
            bus.grant1  <= 1'b0;
            bus.done    <= 1'b0;
            bus.busy    <= 1'b0;
            bus.done_id <= 1'b0;
            bus.sum     <= '0;
            sh_a        <= '0;
            sh_b        <= '0;
            res         <= '0;
            carry       <= 1'b0;
            cnt         <= '0;
            served      <= 1'b0;
        end else begin
            bus.grant0 <= grant0_d;
            bus.grant1 <= grant1_d;
            bus.done   <= done_d;
            bus.busy   <= busy_d;
            if (start) begin
                sh_a   <= winner ? bus.a1 : bus.a0;
                sh_b   <= winner ? bus.b1 : bus.b0;
                carry  <= 1'b0;
                cnt    <= '0;
                served <= winner;
            end else if (state == SHIFT) begin
                if (last) begin
                    bus.sum     <= {carry, res};
                    bus.done_id <= served;
                end else begin
                    sh_a  <= sh_a >> 1;
                    sh_b  <= sh_b >> 1;
                    res   <= {fa_sum, res[N-1:1]};
                    carry <= fa_carry;
                    cnt   <= cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_serial_add_sched.sv
// Directed + random bench for serial_add_sched: one N=8 and one N=4 instance, reference model in plain arithmetic.
module tb_serial_add_sched;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  serial_add_sched_if #(.N(8)) b8 ();
  serial_add_sched_if #(.N(4)) b4 ();
  logic [1:0] st8, st4;

  serial_add_sched #(.N(8)) u8 (.clock(clock), .reset(reset), .bus(b8.slave), .fsm_state(st8));
  serial_add_sched #(.N(4)) u4 (.clock(clock), .reset(reset), .bus(b4.slave), .fsm_state(st4));

  int checks = 0;
  int errors = 0;
  int use4 = 0;
  int ptr = 0;
  bit rr_build;
  logic [16:0] exp_q[$];
  int id_q[$];

  logic r0_v, r1_v;
  logic [15:0] a0_v, b0_v, a1_v, b1_v;

  logic g0, g1, dn, did, bsy;
  logic [16:0] sm;
  assign g0  = use4 ? b4.grant0 : b8.grant0;
  assign g1  = use4 ? b4.grant1 : b8.grant1;
  assign dn  = use4 ? b4.done : b8.done;
  assign did = use4 ? b4.done_id : b8.done_id;
  assign bsy = use4 ? b4.busy : b8.busy;
  assign sm  = use4 ? {12'd0, b4.sum} : {8'd0, b8.sum};

  function automatic int nbits();
    return use4 ? 4 : 8;
  endfunction

  function automatic logic [15:0] msk(input logic [15:0] v);
    return v & 16'((1 << nbits()) - 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    b8.req0 = use4 ? 1'b0 : r0_v;
    b8.req1 = use4 ? 1'b0 : r1_v;
    b8.a0 = a0_v[7:0]; b8.b0 = b0_v[7:0]; b8.a1 = a1_v[7:0]; b8.b1 = b1_v[7:0];
    b4.req0 = use4 ? r0_v : 1'b0;
    b4.req1 = use4 ? r1_v : 1'b0;
    b4.a0 = a0_v[3:0]; b4.b0 = b0_v[3:0]; b4.a1 = a1_v[3:0]; b4.b1 = b1_v[3:0];
  endtask

  task automatic set_req(input logic r0, input logic r1, input logic [15:0] x0, input logic [15:0] y0,
                         input logic [15:0] x1, input logic [15:0] y1);
    r0_v = r0; r1_v = r1;
    a0_v = msk(x0); b0_v = msk(y0); a1_v = msk(x1); b1_v = msk(y1);
    apply();
  endtask

  function automatic int exp_winner();
    if (r0_v && r1_v) return rr_build ? ptr : 0;
    return r1_v ? 1 : 0;
  endfunction

  // Waits for a grant, checks the arbitration choice and queues the expected result.
  task automatic wait_grant(output int id, output int waited);
    int ew;
    ew = exp_winner();
    id = -1;
    waited = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      waited = k;
      chk("grant_excl", {31'd0, g0 & g1}, 32'd0);
      if (g0 | g1) begin
        id = g1 ? 1 : 0;
        break;
      end
    end
    chk("grant_seen", {31'd0, id >= 0}, 32'd1);
    chk("grant_id", id, ew);
    exp_q.push_back(ew == 1 ? 17'(a1_v + b1_v) : 17'(a0_v + b0_v));
    id_q.push_back(ew);
    ptr = 1 - ew;
  endtask

  task automatic wait_done();
    int k;
    logic [16:0] es;
    int eid;
    k = 0;
    for (int i = 0; i < 3 * nbits(); i++) begin
      @(negedge clock);
      k++;
      chk("busy_op", {31'd0, bsy}, 32'd1);
      chk("grant_pulse", {31'd0, g0 | g1}, 32'd0);
      if (dn) break;
    end
    chk("latency", k, nbits() + 1);
    es = exp_q.pop_front();
    eid = id_q.pop_front();
    chk("sum", {15'd0, sm}, {15'd0, es});
    chk("done_id", {31'd0, did}, eid);
    @(negedge clock);
    chk("done_pulse", {31'd0, dn}, 32'd0);
    chk("busy_idle", {31'd0, bsy}, 32'd0);
  endtask

  // One operation; the granted requester drops req and scrambles its operands right after grant.
  task automatic do_op();
    int id, w;
    wait_grant(id, w);
    if (id == 1) begin
      r1_v = 1'b0; a1_v = msk(16'($urandom)); b1_v = msk(16'($urandom));
    end else begin
      r0_v = 1'b0; a0_v = msk(16'($urandom)); b0_v = msk(16'($urandom));
    end
    @(negedge clock);
    apply();
    wait_done_after_one();
  endtask

  // Same as wait_done but one SHIFT cycle was already consumed by the caller.
  task automatic wait_done_after_one();
    int k;
    logic [16:0] es;
    int eid;
    k = 1;
    chk("busy_op", {31'd0, bsy}, 32'd1);
    for (int i = 0; i < 3 * nbits(); i++) begin
      @(negedge clock);
      k++;
      chk("busy_op", {31'd0, bsy}, 32'd1);
      chk("grant_pulse", {31'd0, g0 | g1}, 32'd0);
      if (dn) break;
    end
    chk("latency", k, nbits() + 1);
    es = exp_q.pop_front();
    eid = id_q.pop_front();
    chk("sum", {15'd0, sm}, {15'd0, es});
    chk("done_id", {31'd0, did}, eid);
    @(negedge clock);
    chk("done_pulse", {31'd0, dn}, 32'd0);
    chk("busy_idle", {31'd0, bsy}, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_req(0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clock);
    chk("rst_busy", {31'd0, bsy}, 32'd0);
    chk("rst_done", {31'd0, dn}, 32'd0);
    chk("rst_grant", {30'd0, g1, g0}, 32'd0);
    chk("rst_sum", {15'd0, sm}, 32'd0);
    chk("rst_done_id", {31'd0, did}, 32'd0);
    reset = 1'b0;
    ptr = 0;
    exp_q.delete();
    id_q.delete();
    @(negedge clock);
    chk("idle_busy", {31'd0, bsy}, 32'd0);
  endtask

  task automatic random_ops(input int count);
    int pat;
    for (int i = 0; i < count; i++) begin
      pat = $urandom_range(0, 2);
      set_req(pat != 1, pat != 0, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      do_op();
    end
  endtask

  initial begin
    int id, w;
`ifdef SERIAL_ADD_SCHED_RR_EN
    rr_build = 1'b1;
`else
    rr_build = 1'b0;
`endif
    do_reset();

    // Max operands, carry out lands in sum[N].
    set_req(1, 0, 255, 255, 0, 0);
    do_op();
    chk("sum_510", {15'd0, sm}, 32'd510);

    // Zero then a fresh add: no stale carry.
    set_req(0, 1, 0, 0, 0, 0);
    do_op();
    chk("sum_zero", {15'd0, sm}, 32'd0);
    set_req(0, 1, 0, 0, 1, 127);
    do_op();
    chk("sum_128", {15'd0, sm}, 32'd128);

    // Both held for four operations: back-to-back spacing and tie breaking.
    set_req(1, 1, 10, 20, 100, 200);
    for (int i = 0; i < 4; i++) begin
      wait_grant(id, w);
      if (i > 0) chk("b2b_gap", w, 1);
      chk("tie_seq", id, (rr_build && (i % 2 == 1)) ? 1 : 0);
      wait_done();
    end
    set_req(0, 0, 0, 0, 0, 0);

    // Reset during the 4th SHIFT cycle drops the operation.
    @(negedge clock);
    set_req(1, 0, 200, 100, 0, 0);
    wait_grant(id, w);
    set_req(0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("mid_rst_busy", {31'd0, bsy}, 32'd0);
    chk("mid_rst_sum", {15'd0, sm}, 32'd0);
    chk("mid_rst_done", {31'd0, dn}, 32'd0);
    ptr = 0;
    exp_q.delete();
    id_q.delete();
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      chk("no_done_after_rst", {31'd0, dn}, 32'd0);
      chk("no_grant_after_rst", {30'd0, g1, g0}, 32'd0);
    end
    set_req(0, 1, 0, 0, 3, 4);
    do_op();
    chk("sum_after_rst", {15'd0, sm}, 32'd7);

    random_ops(500);

    use4 = 1;
    do_reset();
    set_req(1, 0, 15, 15, 0, 0);
    do_op();
    chk("sum4_max", {15'd0, sm}, 32'd30);
    random_ops(500);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
